dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = pipeline MEM stage,

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/arb_starve_counter.sv | 31 +++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and request-owner encoding.
package dmem_arb_pkg;

    // IDLE: no access issued next cycle, BUSY: access issued next cycle,
    // LOCK: p1 holds the memory across consecutive grants.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    // Which port an issued access belongs to, so the response can be routed back.
    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles in which port 1 asked and was refused.
// The sat flag lets port 1 override port 0 priority once it has waited long enough.
module arb_starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic sat
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] count;

    // Count refused cycles; any grant or a dropped request starts the wait over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!req || gnt) begin
            count <= '0;
        end else if (!sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port 0 is the
// pipeline MEM stage, port 1 the DMA/debug loader. A grant in cycle N drives the
// memory from registers in N+1; read data returns with a valid pulse in N+2.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              p1_sat;

    logic              iss_valid;
    owner_t            iss_owner;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (p1_req),
        .gnt   (p1_gnt),
        .sat   (p1_sat)
    );

    // State register; reset drops any lock ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection and next state: lock owner first, then a starved p1,
    // then p0, then p1. Grants are held off entirely while reset is asserted.
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        state_nxt = state;

        if (rst_n) begin
            if (state == LOCK) begin
                p1_gnt = p1_req;
            end else if (p1_sat && p1_req) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end

        if (p1_gnt && p1_lock) begin
            state_nxt = LOCK;
        end else if (state == LOCK) begin
            if (p1_lock) begin
                state_nxt = LOCK;
            end else if (p1_gnt) begin
                state_nxt = BUSY;
            end else begin
                state_nxt = IDLE;
            end
        end else if (p0_gnt || p1_gnt) begin
            state_nxt = BUSY;
        end else begin
            state_nxt = IDLE;
        end
    end

    // Issue registers: capture the winning request so the memory sees it next
    // cycle; with no grant everything returns to zero so the bus reads as idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_owner <= OWN_P0;
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end else if (p0_gnt) begin
            iss_valid <= 1'b1;
            iss_owner <= OWN_P0;
            iss_we    <= p0_we;
            iss_addr  <= p0_addr;
            iss_wdata <= p0_wdata;
        end else if (p1_gnt) begin
            iss_valid <= 1'b1;
            iss_owner <= OWN_P1;
            iss_we    <= p1_we;
            iss_addr  <= p1_addr;
            iss_wdata <= p1_wdata;
        end else begin
            iss_valid <= 1'b0;
            iss_owner <= OWN_P0;
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end
    end

    assign mem_read  = iss_valid & ~iss_we;
    assign mem_write = iss_valid & iss_we;
    assign mem_addr  = iss_addr;
    assign mem_wdata = iss_wdata;

    // Response registers: latch the combinational read data for the owning port
    // and pulse its valid; read data holds until that port's next read returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= mem_read && (iss_owner == OWN_P0);
            p1_rvalid <= mem_read && (iss_owner == OWN_P1);
            if (mem_read && (iss_owner == OWN_P0)) begin
                p0_rdata <= mem_rdata;
            end
            if (mem_read && (iss_owner == OWN_P1)) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of arbitration, memory contents and response timing.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_lock   (p1_lock),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: 16 words, combinational read, write on the edge.
    logic [DATA_W-1:0] env_mem [16];
    assign mem_rdata = env_mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write) env_mem[mem_addr[5:2]] <= mem_wdata;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model state
    bit                m_locked;
    int                m_waits;
    bit                m_iss_v, m_iss_own, m_iss_we;
    logic [ADDR_W-1:0] m_iss_a;
    logic [DATA_W-1:0] m_iss_d;
    bit                m_rv [2];
    logic [DATA_W-1:0] m_rd [2];
    logic [DATA_W-1:0] shadow [16];

    always @(negedge clk) begin : compare
        bit e0, e1;
        if (!rst_n) begin
            m_locked = 1'b0; m_waits = 0;
            m_iss_v = 1'b0; m_iss_own = 1'b0; m_iss_we = 1'b0; m_iss_a = '0; m_iss_d = '0;
            m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
            checkOutput("rst_p0_gnt", p0_gnt, 0);
            checkOutput("rst_p1_gnt", p1_gnt, 0);
            checkOutput("rst_mem_read", mem_read, 0);
            checkOutput("rst_mem_write", mem_write, 0);
            checkOutput("rst_mem_addr", mem_addr, 0);
            checkOutput("rst_p0_rvalid", p0_rvalid, 0);
            checkOutput("rst_p1_rvalid", p1_rvalid, 0);
            checkOutput("rst_p0_rdata", p0_rdata, 0);
            checkOutput("rst_p1_rdata", p1_rdata, 0);
        end else begin
            e0 = 1'b0; e1 = 1'b0;
            if (m_locked) e1 = p1_req;
            else if (m_waits >= MAX_WAIT && p1_req) e1 = 1'b1;
            else if (p0_req) e0 = 1'b1;
            else if (p1_req) e1 = 1'b1;

            checkOutput("p0_gnt", p0_gnt, e0);
            checkOutput("p1_gnt", p1_gnt, e1);
            checkOutput("mem_read", mem_read, m_iss_v && !m_iss_we);
            checkOutput("mem_write", mem_write, m_iss_v && m_iss_we);
            checkOutput("mem_addr", mem_addr, m_iss_v ? m_iss_a : 32'h0);
            if (!(m_iss_v && !m_iss_we))
                checkOutput("mem_wdata", mem_wdata, m_iss_v ? m_iss_d : 32'h0);
            checkOutput("p0_rvalid", p0_rvalid, m_rv[0]);
            checkOutput("p1_rvalid", p1_rvalid, m_rv[1]);
            checkOutput("p0_rdata", p0_rdata, m_rd[0]);
            checkOutput("p1_rdata", p1_rdata, m_rd[1]);

            // What the coming edge does: reads return, writes land, grant issues.
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (m_iss_v && !m_iss_we) begin
                m_rv[m_iss_own] = 1'b1;
                m_rd[m_iss_own] = shadow[m_iss_a[5:2]];
            end
            if (m_iss_v && m_iss_we) shadow[m_iss_a[5:2]] = m_iss_d;

            m_iss_v   = e0 | e1;
            m_iss_own = e1;
            m_iss_we  = e1 ? p1_we : (e0 ? p0_we : 1'b0);
            m_iss_a   = e1 ? p1_addr : (e0 ? p0_addr : '0);
            m_iss_d   = e1 ? p1_wdata : (e0 ? p0_wdata : '0);

            if (p1_req && !e1) m_waits = (m_waits < MAX_WAIT) ? m_waits + 1 : MAX_WAIT;
            else m_waits = 0;

            if (e1 && p1_lock) m_locked = 1'b1;
            else if (!p1_lock) m_locked = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic lk);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
    endtask

    function automatic logic [31:0] randAddr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        bit g0_seen, g1_seen;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = '0;
            shadow[i]  = '0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] idle period");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t6_mem_rw", {mem_read, mem_write}, 0);
            checkOutput("t6_rvalid", {p0_rvalid, p1_rvalid}, 0);
            tick();
        end

        $display("[TB] p0 write then read back");
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t1_wr_gnt", p0_gnt, 1); tick();
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_rd_gnt", p0_gnt, 1);
        checkOutput("t1_mem_write", mem_write, 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h10);
        checkOutput("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t1_mem_read", mem_read, 1); tick();
        @(negedge clk);
        checkOutput("t1_rvalid", p0_rvalid, 1);
        checkOutput("t1_rdata", p0_rdata, 32'hDEADBEEF);
        tick();

        $display("[TB] continuous contention");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0);
            @(negedge clk);
            checkOutput("t2_p0_gnt", p0_gnt, (i % 5) != 4);
            checkOutput("t2_p1_gnt", p1_gnt, (i % 5) == 4);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("[TB] p1 lock");
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h8, 0, 1);
        @(negedge clk); checkOutput("t3_p1_gnt0", p1_gnt, 1); tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1);
            @(negedge clk);
            checkOutput("t3_p0_blocked", p0_gnt, 0);
            checkOutput("t3_p1_gnt", p1_gnt, 1);
            tick();
        end
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t3_drop_cycle", p0_gnt, 0); tick();
        @(negedge clk); checkOutput("t3_p0_after", p0_gnt, 1); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("[TB] reset during p1 write");
        applyStimulus(1, 1, 32'h20, 32'h55AA55AA, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'hCAFEF00D, 0);
        @(negedge clk); checkOutput("t4_p1_gnt", p1_gnt, 1); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t4_mem_write", mem_write, 0);
        checkOutput("t4_p1_rvalid", p1_rvalid, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t4_post_write", mem_write, 0);
            checkOutput("t4_post_rvalid", p1_rvalid, 0);
            tick();
        end
        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checkOutput("t4_rb_rvalid", p0_rvalid, 1);
        checkOutput("t4_rb_rdata", p0_rdata, 32'h55AA55AA);
        tick();

        $display("[TB] p0 write, p1 read same address");
        applyStimulus(1, 1, 32'h04, 32'h1, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t5_p0_gnt", p0_gnt, 1); tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h04, 0, 0);
        @(negedge clk); checkOutput("t5_p1_gnt", p1_gnt, 1); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checkOutput("t5_rvalid", p1_rvalid, 1);
        checkOutput("t5_rdata", p1_rdata, 32'h1);
        tick();

        $display("[TB] randomized traffic");
        g0_seen = 1'b0; g1_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!p0_req || g0_seen) begin
                p0_req   = ($urandom_range(0, 99) < 60);
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = randAddr();
                p0_wdata = $urandom;
            end
            if (!p1_req || g1_seen) begin
                p1_req   = ($urandom_range(0, 99) < 50);
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = randAddr();
                p1_wdata = $urandom;
            end
            p1_lock = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                rst_n = 1'b1;
            end
            @(negedge clk);
            g0_seen = p0_gnt;
            g1_seen = p1_gnt;
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
